// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline encodings for the hazard scoreboard: operand-use timing,
// forward-select codes and multiply/divide occupancy lengths.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    TUSE_D    = 2'd0,
    TUSE_E    = 2'd1,
    TUSE_M    = 2'd2,
    TUSE_NONE = 2'd3
  } tuse_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  localparam logic [3:0] MD_MULT_CYC = 4'd5;
  localparam logic [3:0] MD_DIV_CYC  = 4'd10;

  // Countdown of remaining result latency, saturating at zero.
  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Occupancy counter for the multiply/divide unit; a start is only accepted
// on a cycle where the D-stage instruction is not stalled.
module md_busy_counter
  import hazard_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic md_start_i,
  input  logic md_is_div_i,
  input  logic stall_i,
  output logic md_busy_o
);

  logic [3:0] busy_cnt_q;
  logic [3:0] busy_cnt_d;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (md_start_i && !stall_i) begin
      busy_cnt_d = md_is_div_i ? MD_DIV_CYC : MD_MULT_CYC;
    end else if (busy_cnt_q != 4'd0) begin
      busy_cnt_d = busy_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt_q <= 4'd0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign md_busy_o = (busy_cnt_q != 4'd0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: tracks destination/latency of instructions in E, M, W
// and produces the stall and operand forward selects for the D-stage sources.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] tnew_D,
  input  logic [4:0] who_new_D,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic       md_start_D,
  input  logic       md_is_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic       md_busy
);

  logic [1:0] tnew_e_q, tnew_e_d;
  logic [1:0] tnew_m_q, tnew_m_d;
  logic [4:0] who_e_q, who_e_d;
  logic [4:0] who_m_q, who_m_d;
  logic [4:0] who_w_q, who_w_d;
  logic       stall_rs, stall_rt, stall_md;

  // A source stalls when a producer in E or M will not have its result
  // ready by the time the D-stage instruction needs it.
  function automatic logic data_stall(
    input logic [4:0] src, input logic [1:0] tuse,
    input logic [4:0] w_e, input logic [1:0] t_e,
    input logic [4:0] w_m, input logic [1:0] t_m
  );
    return (src != 5'd0) && (tuse != TUSE_NONE) &&
           (((w_e == src) && (t_e > tuse)) || ((w_m == src) && (t_m > tuse)));
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] w_e, input logic [1:0] t_e,
    input logic [4:0] w_m, input logic [1:0] t_m,
    input logic [4:0] w_w
  );
    if (src == 5'd0)                     return FWD_RF;
    if ((w_e == src) && (t_e == 2'd0))   return FWD_E;
    if ((w_m == src) && (t_m == 2'd0))   return FWD_M;
    if (w_w == src)                      return FWD_W;
    return FWD_RF;
  endfunction

  assign stall_rs = data_stall(rs_D, tuse_rs_D, who_e_q, tnew_e_q, who_m_q, tnew_m_q);
  assign stall_rt = data_stall(rt_D, tuse_rt_D, who_e_q, tnew_e_q, who_m_q, tnew_m_q);
  assign stall_md = md_use_D && md_busy;
  assign stall    = stall_rs || stall_rt || stall_md;

  assign fwd_rs_D = fwd_sel(rs_D, who_e_q, tnew_e_q, who_m_q, tnew_m_q, who_w_q);
  assign fwd_rt_D = fwd_sel(rt_D, who_e_q, tnew_e_q, who_m_q, tnew_m_q, who_w_q);

  // A stall turns the E slot into a bubble while M and W keep draining.
  always_comb begin
    tnew_e_d = stall ? 2'd0 : sat_dec(tnew_D);
    who_e_d  = stall ? 5'd0 : who_new_D;
    tnew_m_d = sat_dec(tnew_e_q);
    who_m_d  = who_e_q;
    who_w_d  = who_m_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tnew_e_q <= 2'd0;
      who_e_q  <= 5'd0;
      tnew_m_q <= 2'd0;
      who_m_q  <= 5'd0;
      who_w_q  <= 5'd0;
    end else begin
      tnew_e_q <= tnew_e_d;
      who_e_q  <= who_e_d;
      tnew_m_q <= tnew_m_d;
      who_m_q  <= who_m_d;
      who_w_q  <= who_w_d;
    end
  end

  md_busy_counter u_md_busy_counter (
    .clk         (clk),
    .reset       (reset),
    .md_start_i  (md_start_D),
    .md_is_div_i (md_is_div_D),
    .stall_i     (stall),
    .md_busy_o   (md_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus
// random instruction streams against an age-based reference model.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic [1:0] tnew_D;
  logic [4:0] who_new_D, rs_D, rt_D;
  logic [1:0] tuse_rs_D, tuse_rt_D;
  logic       md_start_D, md_is_div_D, md_use_D;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .tnew_D(tnew_D), .who_new_D(who_new_D),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .md_start_D(md_start_D), .md_is_div_D(md_is_div_D), .md_use_D(md_use_D),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .md_busy(md_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] tnew;
    logic [4:0] who;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       md_start;
    logic       md_div;
    logic       md_use;
  } instr_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: instruction in E/M/W is at age 1/2/3 after D; its
  // remaining latency is the issue-time tnew minus its age, floored at 0.
  logic [4:0] m_who [1:3];
  int         m_tnew[1:3];
  int         cyc;
  int         busy_end;
  bit         obs_stall, obs_busy, exp_stall_last;
  int         obs_frs, obs_frt;

  function automatic int rem(input int k);
    int r;
    r = m_tnew[k] - k;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit src_stall(input logic [4:0] r, input logic [1:0] tuse);
    if (r == 0 || tuse == 2'd3) return 1'b0;
    for (int k = 1; k <= 2; k++)
      if (m_who[k] == r && rem(k) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int src_fwd(input logic [4:0] r);
    if (r == 0) return 0;
    for (int k = 1; k <= 3; k++)
      if (m_who[k] == r && (k == 3 || rem(k) == 0)) return k;
    return 0;
  endfunction

  function automatic instr_t mk(input int tnew, input int who, input int rs, input int rt,
                                input int urs, input int urt, input bit st, input bit dv,
                                input bit use_md);
    instr_t x;
    x.tnew = 2'(tnew); x.who = 5'(who); x.rs = 5'(rs); x.rt = 5'(rt);
    x.tuse_rs = 2'(urs); x.tuse_rt = 2'(urt);
    x.md_start = st; x.md_div = dv; x.md_use = use_md;
    return x;
  endfunction

  function automatic instr_t nop_i();                      return mk(0, 0, 0, 0, 3, 3, 0, 0, 0); endfunction
  function automatic instr_t alu_i(input int d, s, t);     return mk(2, d, s, t, 1, 1, 0, 0, 0); endfunction
  function automatic instr_t lw_i(input int d, s);         return mk(3, d, s, 0, 1, 3, 0, 0, 0); endfunction
  function automatic instr_t sw_i(input int s, t);         return mk(0, 0, s, t, 1, 2, 0, 0, 0); endfunction
  function automatic instr_t beq_i(input int s, t);        return mk(0, 0, s, t, 0, 0, 0, 0, 0); endfunction
  function automatic instr_t md_i(input int s, t, bit dv); return mk(0, 0, s, t, 1, 1, 1, dv, 1); endfunction
  function automatic instr_t mf_i(input int d);            return mk(2, d, 0, 0, 3, 3, 0, 0, 1); endfunction
  function automatic instr_t mt_i(input int s);            return mk(0, 0, s, 0, 1, 3, 0, 0, 1); endfunction
  function automatic instr_t jal_i();                      return mk(0, 31, 0, 0, 3, 3, 0, 0, 0); endfunction

  // driver: one clock of D-stage input, checked at the falling edge
  task automatic cycle(input instr_t in, input bit rst, input bit chk);
    bit e_busy, e_stall;
    int e_frs, e_frt;
    reset = rst;
    tnew_D = in.tnew; who_new_D = in.who; rs_D = in.rs; rt_D = in.rt;
    tuse_rs_D = in.tuse_rs; tuse_rt_D = in.tuse_rt;
    md_start_D = in.md_start; md_is_div_D = in.md_div; md_use_D = in.md_use;
    @(negedge clk);
    e_busy  = (cyc <= busy_end);
    e_stall = src_stall(in.rs, in.tuse_rs) || src_stall(in.rt, in.tuse_rt) ||
              (in.md_use && e_busy);
    e_frs = src_fwd(in.rs);
    e_frt = src_fwd(in.rt);
    if (chk) begin
      check_val("stall",    32'(stall),    32'(e_stall));
      check_val("md_busy",  32'(md_busy),  32'(e_busy));
      check_val("fwd_rs_D", 32'(fwd_rs_D), 32'(e_frs));
      check_val("fwd_rt_D", 32'(fwd_rt_D), 32'(e_frt));
    end
    obs_stall = stall; obs_busy = md_busy;
    obs_frs = int'(fwd_rs_D); obs_frt = int'(fwd_rt_D);
    exp_stall_last = e_stall;
    @(posedge clk);
    if (rst) begin
      for (int k = 1; k <= 3; k++) begin m_who[k] = 0; m_tnew[k] = 0; end
      busy_end = cyc;
    end else begin
      m_who[3] = m_who[2]; m_tnew[3] = m_tnew[2];
      m_who[2] = m_who[1]; m_tnew[2] = m_tnew[1];
      m_who[1] = e_stall ? 5'd0 : in.who;
      m_tnew[1] = e_stall ? 0 : int'(in.tnew);
      if (in.md_start && !e_stall) busy_end = cyc + (in.md_div ? 10 : 5);
    end
    cyc++;
    #1;
  endtask

  // hold one instruction in D until the DUT lets it advance
  task automatic issue(input instr_t in, output int n_stall, output int n_busy,
                       output int frs, output int frt);
    bit accepted;
    accepted = 0; n_stall = 0; n_busy = 0; frs = 0; frt = 0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      cycle(in, 1'b0, 1'b1);
      if (obs_busy) n_busy++;
      if (!obs_stall) begin
        accepted = 1; frs = obs_frs; frt = obs_frt;
      end else begin
        n_stall++;
      end
    end
    check_val("issue_accept", 32'(accepted), 32'd1);
  endtask

  int ns, nb, fr, ft;
  instr_t ri;

  initial begin
    cyc = 0; busy_end = -1;
    for (int k = 1; k <= 3; k++) begin m_who[k] = 0; m_tnew[k] = 0; end
    @(posedge clk); #1;
    cycle(nop_i(), 1'b1, 1'b0);
    cycle(nop_i(), 1'b0, 1'b1);

    // load-use: one stall cycle, then the value arrives via W next
    issue(lw_i(3, 0), ns, nb, fr, ft);
    issue(alu_i(4, 3, 5), ns, nb, fr, ft);
    check_val("lw_use_stalls", 32'(ns), 32'd1);
    issue(alu_i(6, 3, 0), ns, nb, fr, ft);
    check_val("lw_w_fwd", 32'(fr), 32'd3);

    // ALU result into a branch compare
    cycle(nop_i(), 1'b1, 1'b1);
    issue(alu_i(2, 7, 8), ns, nb, fr, ft);
    issue(beq_i(2, 0), ns, nb, fr, ft);
    check_val("alu_beq_stalls", 32'(ns), 32'd1);
    check_val("alu_beq_fwd", 32'(fr), 32'd2);

    // ALU result into store data: no stall, M forward one cycle later
    cycle(nop_i(), 1'b1, 1'b1);
    issue(alu_i(2, 7, 8), ns, nb, fr, ft);
    issue(sw_i(0, 2), ns, nb, fr, ft);
    check_val("alu_sw_stalls", 32'(ns), 32'd0);
    check_val("alu_sw_fwd0", 32'(ft), 32'd0);
    issue(sw_i(0, 2), ns, nb, fr, ft);
    check_val("alu_sw_fwd1", 32'(ft), 32'd2);

    // div then mflo
    cycle(nop_i(), 1'b1, 1'b1);
    issue(md_i(1, 2, 1'b1), ns, nb, fr, ft);
    issue(mf_i(4), ns, nb, fr, ft);
    check_val("div_mflo_stalls", 32'(ns), 32'd10);
    check_val("div_mflo_busy", 32'(nb), 32'd10);

    // register 0 never hazards
    cycle(nop_i(), 1'b1, 1'b1);
    issue(lw_i(0, 1), ns, nb, fr, ft);
    issue(alu_i(5, 0, 0), ns, nb, fr, ft);
    check_val("r0_stalls", 32'(ns), 32'd0);
    check_val("r0_fwd_rs", 32'(fr), 32'd0);
    check_val("r0_fwd_rt", 32'(ft), 32'd0);

    // reset mid-mult frees a waiting mfhi
    cycle(nop_i(), 1'b1, 1'b1);
    issue(md_i(1, 2, 1'b0), ns, nb, fr, ft);
    cycle(nop_i(), 1'b0, 1'b1);
    cycle(nop_i(), 1'b0, 1'b1);
    cycle(mf_i(7), 1'b1, 1'b1);
    issue(mf_i(7), ns, nb, fr, ft);
    check_val("rst_mult_stalls", 32'(ns), 32'd0);
    check_val("rst_mult_busy", 32'(nb), 32'd0);

    // random instruction streams; a stalled instruction is retried
    ri = nop_i();
    for (int n = 0; n < 800; n++) begin
      if (!exp_stall_last) begin
        case ($urandom_range(0, 8))
          0: ri = alu_i($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
          1: ri = lw_i($urandom_range(0, 4), $urandom_range(0, 4));
          2: ri = sw_i($urandom_range(0, 4), $urandom_range(0, 4));
          3: ri = beq_i($urandom_range(0, 4), $urandom_range(0, 4));
          4: ri = md_i($urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
          5: ri = mf_i($urandom_range(0, 4));
          6: ri = mt_i($urandom_range(0, 4));
          7: ri = jal_i();
          default: ri = nop_i();
        endcase
      end
      cycle(ri, ($urandom_range(0, 59) == 0), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
